// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write arbiter and its FIFO.
package fifo_arb_pkg;

    // Arbiter FSM states: ARB picks an owner, BURST streams its beats.
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Data width shared with the Synchronous_FIFO this block feeds.
    localparam int FIFO_WIDTH = 8;

    // Width of a requester index; never below one bit.
    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshakes and FIFO write port seen by the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = FIFO_WIDTH
);
    logic [N-1:0]       req_valid;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_ready;
    logic [WIDTH-1:0]   fifo_data_in;
    logic               fifo_wr_en;
    logic               fifo_full;

    // Arbiter view: consumes requests and FIFO status, drives accepts and the write.
    modport master (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_data_in,
        output fifo_wr_en
    );

    // Environment view: producers plus FIFO.
    modport slave (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_data_in,
        input  fifo_wr_en
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request searching cyclically from last_id+1.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = idw_of(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_id,
    output logic [IDW-1:0] winner,
    output logic           any_req
);
    logic [N-1:0] rot_s;
    int           start_s;
    int           off_s;

    // Rotate so last_id+1 sits at bit 0, priority-encode, rotate the index back.
    always_comb begin
        start_s = (int'(last_id) + 32'sd1) % N;
        rot_s   = '0;
        off_s   = 0;
        for (int i = 0; i < N; i++) begin
            rot_s[i] = req[(start_s + i) % N];
        end
        // Walk downwards so the lowest set bit is the one that sticks.
        for (int i = N - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? i : off_s;
        end
        winner  = IDW'((start_s + off_s) % N);
        any_req = |req;
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers in bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int MAX_BURST = 4,
    parameter int IDW       = idw_of(N)
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus,
    output logic [IDW-1:0]    grant_id,
    output logic              busy
);
    localparam int BCW = $clog2(MAX_BURST + 1);

    arb_state_e       state_r, state_nx_s;
    logic [IDW-1:0]   grant_id_r, grant_nx_s;
    logic [IDW-1:0]   last_id_r, last_nx_s;
    logic [BCW-1:0]   beat_cnt_r, beat_nx_s;
    logic [IDW-1:0]   winner_s;
    logic             any_req_s;
    logic [N-1:0]     ready_s;
    logic             wr_en_s;
    logic [WIDTH-1:0] data_s;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req     (bus.req_valid),
        .last_id (last_id_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    // State, owner, fairness pointer and beat counter; last_id starts at N-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ARB;
            grant_id_r <= '0;
            last_id_r  <= IDW'(N - 1);
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_nx_s;
            grant_id_r <= grant_nx_s;
            last_id_r  <= last_nx_s;
            beat_cnt_r <= beat_nx_s;
        end
    end

    // Next-state logic and the owner's datapath; outputs stay quiet in ARB and while rst is high.
    always_comb begin
        state_nx_s = state_r;
        grant_nx_s = grant_id_r;
        last_nx_s  = last_id_r;
        beat_nx_s  = beat_cnt_r;
        ready_s    = '0;
        wr_en_s    = 1'b0;
        data_s     = '0;
        case (state_r)
            ARB: begin
                if (any_req_s) begin
                    state_nx_s = BURST;
                    grant_nx_s = winner_s;
                    last_nx_s  = winner_s;
                    beat_nx_s  = '0;
                end else begin
                    state_nx_s = ARB;
                end
            end
            BURST: begin
                if (!rst) begin
                    ready_s[grant_id_r] = ~bus.fifo_full;
                    wr_en_s = bus.req_valid[grant_id_r] & ~bus.fifo_full;
                    data_s  = bus.req_data[int'(grant_id_r) * WIDTH +: WIDTH];
                end else begin
                    ready_s = '0;
                    wr_en_s = 1'b0;
                    data_s  = '0;
                end
                if (!bus.req_valid[grant_id_r]) begin
                    // Owner went idle: release without a transfer.
                    state_nx_s = ARB;
                end else if (wr_en_s) begin
                    if (beat_cnt_r == BCW'(MAX_BURST - 1)) begin
                        state_nx_s = ARB;
                    end else begin
                        beat_nx_s = beat_cnt_r + BCW'(1);
                    end
                end else begin
                    // FIFO full: hold everything until space appears.
                    state_nx_s = BURST;
                end
            end
            default: begin
                state_nx_s = ARB;
            end
        endcase
    end

    assign bus.req_ready    = ready_s;
    assign bus.fifo_wr_en   = wr_en_s;
    assign bus.fifo_data_in = data_s;
    assign grant_id         = grant_id_r;
    assign busy             = (state_r == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter with a FIFO occupancy model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [IDW-1:0] grant_id;
    logic           busy;

    fifo_wr_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    fifo_wr_arbiter #(
        .N         (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] src_q [N][$];
    logic [7:0] exp_q [N][$];
    beat_t      glob_q[$];
    logic       rand_mode;
    logic       rd_en;
    logic [N-1:0] fire_s;
    logic       wr_seen;
    int         fifo_cnt;
    int         n_vec;
    int         n_err;
    logic [5:0] seq [N];

    logic [3:0]  t1_busy = 4'b0110;
    logic [3:0]  t1_wr   = 4'b0010;
    logic [12:0] t4_busy = 13'b0110111101110;
    logic [12:0] t4_wr   = 13'b0010111100110;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0) begin
                bus.req_valid[k]      = 1'b1;
                bus.req_data[k*W +: W] = src_q[k][0];
            end else begin
                bus.req_valid[k]      = 1'b0;
                bus.req_data[k*W +: W] = 8'h00;
            end
        end
        bus.fifo_full = (fifo_cnt >= DEPTH);
    endtask

    task automatic push_exp(input int k, input logic [7:0] d);
        beat_t b;
        if (rand_mode) begin
            exp_q[k].push_back(d);
        end else begin
            b.id   = k[1:0];
            b.data = d;
            glob_q.push_back(b);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        src_q[k].push_back(d);
        push_exp(k, d);
    endtask

    // Mid-cycle sampling: invariants plus scoreboard on every write.
    task automatic sample();
        beat_t      b;
        logic [1:0] tag;
        logic [7:0] e;
        @(negedge clk);
        fire_s  = bus.req_valid & bus.req_ready;
        wr_seen = bus.fifo_wr_en;
        chk("onehot_ready", 32'($onehot0(bus.req_ready)), 32'd1);
        chk("wr_while_full", 32'(bus.fifo_wr_en & bus.fifo_full), 32'd0);
        if (bus.fifo_wr_en === 1'b1) begin
            if (rand_mode) begin
                tag = bus.fifo_data_in[7:6];
                chk("rr_grant_tag", 32'(grant_id), 32'(tag));
                chk("rr_write_expected", 32'(exp_q[tag].size() > 0), 32'd1);
                if (exp_q[tag].size() > 0) begin
                    e = exp_q[tag].pop_front();
                    chk("rr_data_order", 32'(bus.fifo_data_in), 32'(e));
                end
            end else begin
                chk("write_expected", 32'(glob_q.size() > 0), 32'd1);
                if (glob_q.size() > 0) begin
                    b = glob_q.pop_front();
                    chk("wr_data", 32'(bus.fifo_data_in), 32'(b.data));
                    chk("wr_grant", 32'(grant_id), 32'(b.id));
                end
            end
        end
    endtask

    // Just after the edge: retire accepted beats, update FIFO occupancy, redrive.
    task automatic advance();
        int c;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (fire_s[k] === 1'b1 && src_q[k].size() > 0) begin
                void'(src_q[k].pop_front());
            end
        end
        c = fifo_cnt;
        if (rd_en && c > 0) fifo_cnt--;
        if (wr_seen === 1'b1) fifo_cnt++;
        chk("no_overflow", 32'(fifo_cnt <= DEPTH), 32'd1);
        fire_s  = '0;
        wr_seen = 1'b0;
        drive();
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += src_q[k].size();
        return s;
    endfunction

    initial begin
        int guard;
        n_vec = 0; n_err = 0; rand_mode = 1'b0; rd_en = 1'b0; fifo_cnt = 0;
        fire_s = '0; wr_seen = 1'b0;
        for (int k = 0; k < N; k++) seq[k] = 6'd0;
        rst = 1'b1;
        drive();
        @(posedge clk); #1;

        // Reset state
        sample();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("rst_data", 32'(bus.fifo_data_in), 32'd0);
        advance();
        rst = 1'b0;

        // 1: single requester, single beat
        push(0, 8'hAA);
        drive();
        for (int t = 0; t < 4; t++) begin
            sample();
            chk("t1_busy", 32'(busy), 32'(t1_busy[t]));
            chk("t1_wr_en", 32'(bus.fifo_wr_en), 32'(t1_wr[t]));
            advance();
        end

        // 2: all four streaming, rotating 4-beat bursts
        rst = 1'b1; step(); rst = 1'b0;
        rd_en = 1'b1;
        for (int h = 0; h < 2; h++)
            for (int k = 0; k < N; k++)
                for (int b = 0; b < 4; b++)
                    push(k, 8'(16 + 16 * k + 4 * h + b));
        drive();
        for (int t = 0; t < 40; t++) begin
            sample();
            chk("t2_busy", 32'(busy), 32'((t % 5) != 0));
            chk("t2_wr_en", 32'(bus.fifo_wr_en), 32'((t % 5) != 0));
            if ((t % 5) != 0) chk("t2_grant", 32'(grant_id), 32'((t / 5) % 4));
            advance();
        end
        chk("t2_all_written", 32'(glob_q.size()), 32'd0);
        for (int i = 0; i < 5; i++) step();

        // 3: backpressure from a full FIFO
        rd_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(1, 8'(8'h50 + i));
        drive();
        guard = 0;
        while (src_q[1].size() > 0 && guard < 100) begin
            step();
            guard++;
        end
        chk("t3_fill_timeout", 32'(guard < 100), 32'd1);
        push(2, 8'hFF);
        drive();
        for (int t = 0; t < 6; t++) begin
            sample();
            chk("t3_full_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            chk("t3_full_ready", 32'(bus.req_ready), 32'd0);
            advance();
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        sample();
        chk("t3_ff_write", 32'(bus.fifo_wr_en), 32'd1);
        advance();
        for (int t = 0; t < 4; t++) step();
        chk("t3_written_once", 32'(glob_q.size()), 32'd0);
        rd_en = 1'b1;
        for (int t = 0; t < 20; t++) step();
        rd_en = 1'b0;

        // 4: early release by requester 3, requester 0 follows with a fresh count
        push(3, 8'h31); push(3, 8'h32);
        for (int i = 1; i <= 5; i++) push(0, 8'(i));
        drive();
        for (int t = 0; t < 13; t++) begin
            sample();
            chk("t4_busy", 32'(busy), 32'(t4_busy[t]));
            chk("t4_wr_en", 32'(bus.fifo_wr_en), 32'(t4_wr[t]));
            if (t4_busy[t]) chk("t4_grant", 32'(grant_id), (t < 4) ? 32'd3 : 32'd0);
            advance();
        end
        rd_en = 1'b1;
        for (int t = 0; t < 10; t++) step();

        // 5: reset during the second beat of requester 2
        push(2, 8'h21);
        src_q[2].push_back(8'h22); src_q[2].push_back(8'h23); src_q[2].push_back(8'h24);
        drive();
        step();
        sample();
        chk("t5_beat1_grant", 32'(grant_id), 32'd2);
        advance();
        rst = 1'b1;
        sample();
        chk("t5_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
        advance();
        rst = 1'b0;
        push(0, 8'h0A); push(1, 8'h1A);
        push_exp(2, 8'h22); push_exp(2, 8'h23); push_exp(2, 8'h24);
        push(3, 8'h3A);
        drive();
        sample();
        chk("t5_post_busy", 32'(busy), 32'd0);
        chk("t5_post_ready", 32'(bus.req_ready), 32'd0);
        advance();
        sample();
        chk("t5_first_grant", 32'(grant_id), 32'd0);
        chk("t5_first_busy", 32'(busy), 32'd1);
        advance();
        guard = 0;
        while (pending() > 0 && guard < 100) begin
            step();
            guard++;
        end
        chk("t5_drain_timeout", 32'(guard < 100), 32'd1);
        for (int t = 0; t < 3; t++) step();
        chk("t5_all_written", 32'(glob_q.size()), 32'd0);

        // 6: random traffic with random FIFO drain
        rand_mode = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            rd_en = ($urandom_range(0, 1) == 1);
            step();
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() < 3 && $urandom_range(0, 2) == 0) begin
                    push(k, {k[1:0], seq[k]});
                    seq[k] = seq[k] + 6'd1;
                end
            end
            drive();
        end
        rd_en = 1'b1;
        guard = 0;
        while (pending() > 0 && guard < 300) begin
            step();
            guard++;
        end
        chk("t6_drain_timeout", 32'(guard < 300), 32'd1);
        for (int t = 0; t < 5; t++) step();
        for (int k = 0; k < N; k++) chk("t6_all_written", 32'(exp_q[k].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
